// File: rtl/riscv_perf_pkg.sv
// Shared definitions for the performance monitor: controller states, counter address map.
package riscv_perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam int NUM_PT       = 9;
  localparam int ADDR_CYC     = 0;
  localparam int ADDR_INSTR   = 1;
  localparam int ADDR_STIF    = 2;
  localparam int ADDR_STEX    = 3;
  localparam int ADDR_PT_BASE = 4;
  localparam int ADDR_PF_BASE = ADDR_PT_BASE + NUM_PT;
  localparam int NUM_CNT      = ADDR_PF_BASE + NUM_PT;

endpackage

// File: rtl/riscv_perf_monitor_if.sv
// Event strobes, control and read port between the core/host side and the perf monitor.
interface riscv_perf_monitor_if #(
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 5
);
  logic              stat_beq;
  logic              stat_bne;
  logic              stat_blt;
  logic              stat_bge;
  logic              stat_bltu;
  logic              stat_bgeu;
  logic              stat_jal;
  logic              stat_jalr;
  logic              stat_PL_flush;
  logic              stat_PL_stall_if;
  logic              stat_PL_stall_ex;
  logic              stat_ecall;
  logic              cfg_enable;
  logic              cfg_clear;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [CNT_W-1:0]  rd_data;
  logic [1:0]        state_o;

  modport master (
    output stat_beq, stat_bne, stat_blt, stat_bge, stat_bltu, stat_bgeu, stat_jal, stat_jalr,
    output stat_PL_flush, stat_PL_stall_if, stat_PL_stall_ex, stat_ecall,
    output cfg_enable, cfg_clear, rd_req, rd_addr,
    input  rd_ack, rd_data, state_o
  );

  modport slave (
    input  stat_beq, stat_bne, stat_blt, stat_bge, stat_bltu, stat_bgeu, stat_jal, stat_jalr,
    input  stat_PL_flush, stat_PL_stall_if, stat_PL_stall_ex, stat_ecall,
    input  cfg_enable, cfg_clear, rd_req, rd_addr,
    output rd_ack, rd_data, state_o
  );
endinterface

// File: rtl/riscv_perf_monitor_counter.sv
// Single wrapping event counter with synchronous clear and signed step in [-4,3].
// Updates on the edge ending an enabled cycle; clear wins over enable.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic signed [2:0] inc,
  output logic [CNT_W-1:0]  cnt
);

  logic [CNT_W-1:0] step;
  assign step = {{(CNT_W-3){inc[2]}}, inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + step;
    end
  end

endmodule

// File: rtl/riscv_perf_monitor.sv
// Perf monitor: IDLE/RUN/HALT controller, 22 event counters, registered req/ack read port.
// Read ack one cycle after accept (pre-update snapshot); back-to-back requests ack every 2 cycles.
module riscv_perf_monitor
  import riscv_perf_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  riscv_perf_monitor_if.slave bus
);

  state_t            state_q;
  logic              count_en;
  logic              rd_accept;
  logic              rd_ack_q;
  logic [CNT_W-1:0]  rd_data_q;
  logic [7:0]        br_types;
  logic              br_any;
  logic              stall_any;
  logic signed [2:0] inc [NUM_CNT];
  logic [CNT_W-1:0]  cnt [NUM_CNT];

  // clear beats enable and ecall; HALT only leaves through clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else if (bus.cfg_clear) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.cfg_enable) state_q <= ST_RUN;
        ST_RUN:  if (bus.stat_ecall) state_q <= ST_HALT;
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign count_en  = (state_q == ST_RUN) && !bus.stat_ecall && !bus.cfg_clear;
  assign br_types  = {bus.stat_jalr, bus.stat_jal, bus.stat_bgeu, bus.stat_bltu,
                      bus.stat_bge, bus.stat_blt, bus.stat_bne, bus.stat_beq};
  assign br_any    = |br_types;
  assign stall_any = bus.stat_PL_stall_if || bus.stat_PL_stall_ex;

  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      inc[i] = 3'sb000;
    end
    inc[ADDR_CYC]  = 3'sb001;
    inc[ADDR_STIF] = bus.stat_PL_stall_if ? 3'sb001 : 3'sb000;
    inc[ADDR_STEX] = bus.stat_PL_stall_ex ? 3'sb001 : 3'sb000;
    // a flushed slot retracts the two wrong-path instructions already counted
    if (stall_any)              inc[ADDR_INSTR] = 3'sb000;
    else if (bus.stat_PL_flush) inc[ADDR_INSTR] = 3'sb110;
    else                        inc[ADDR_INSTR] = 3'sb001;
    inc[ADDR_PT_BASE] = br_any ? 3'sb001 : 3'sb000;
    inc[ADDR_PF_BASE] = (br_any && bus.stat_PL_flush) ? 3'sb001 : 3'sb000;
    for (int k = 1; k < NUM_PT; k++) begin
      inc[ADDR_PT_BASE + k] = br_types[k-1] ? 3'sb001 : 3'sb000;
      inc[ADDR_PF_BASE + k] = (br_types[k-1] && bus.stat_PL_flush) ? 3'sb001 : 3'sb000;
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    perf_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus.cfg_clear),
      .en    (count_en),
      .inc   (inc[g]),
      .cnt   (cnt[g])
    );
  end

  assign rd_accept = bus.rd_req && !rd_ack_q;

  // counters are sampled before this edge's update, so clear/count races return the old value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_ack_q <= rd_accept;
      if (rd_accept) begin
        rd_data_q <= (int'(bus.rd_addr) < NUM_CNT) ? cnt[bus.rd_addr] : '0;
      end
    end
  end

  assign bus.rd_ack  = rd_ack_q;
  assign bus.rd_data = rd_data_q;
  assign bus.state_o = state_q;

endmodule

// File: tb/tb_riscv_perf_monitor.sv
// Directed bench for riscv_perf_monitor: 32-bit instance for function, 4-bit instance for wrap.
module tb_riscv_perf_monitor;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  riscv_perf_monitor_if #(.CNT_W(32), .ADDR_W(5)) bus ();
  riscv_perf_monitor_if #(.CNT_W(4),  .ADDR_W(5)) bus4 ();

  riscv_perf_monitor #(.CNT_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  riscv_perf_monitor #(.CNT_W(4), .ADDR_W(5)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic zero_inputs();
    bus.stat_beq = 0; bus.stat_bne = 0; bus.stat_blt = 0; bus.stat_bge = 0;
    bus.stat_bltu = 0; bus.stat_bgeu = 0; bus.stat_jal = 0; bus.stat_jalr = 0;
    bus.stat_PL_flush = 0; bus.stat_PL_stall_if = 0; bus.stat_PL_stall_ex = 0;
    bus.stat_ecall = 0; bus.cfg_enable = 0; bus.cfg_clear = 0;
    bus.rd_req = 0; bus.rd_addr = '0;
    bus4.stat_beq = 0; bus4.stat_bne = 0; bus4.stat_blt = 0; bus4.stat_bge = 0;
    bus4.stat_bltu = 0; bus4.stat_bgeu = 0; bus4.stat_jal = 0; bus4.stat_jalr = 0;
    bus4.stat_PL_flush = 0; bus4.stat_PL_stall_if = 0; bus4.stat_PL_stall_ex = 0;
    bus4.stat_ecall = 0; bus4.cfg_enable = 0; bus4.cfg_clear = 0;
    bus4.rd_req = 0; bus4.rd_addr = '0;
  endtask

  // one-shot read on the 32-bit instance, bounded wait for the ack
  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    int w = 0;
    bus.rd_req = 1; bus.rd_addr = a;
    do begin @(negedge clk); w++; end while (!bus.rd_ack && w < 4);
    bus.rd_req = 0;
    chk({tag, "_ack"}, {31'b0, bus.rd_ack}, 32'd1);
    chk(tag, bus.rd_data, exp);
  endtask

  task automatic rd4_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    int w = 0;
    bus4.rd_req = 1; bus4.rd_addr = a;
    do begin @(negedge clk); w++; end while (!bus4.rd_ack && w < 4);
    bus4.rd_req = 0;
    chk({tag, "_ack"}, {31'b0, bus4.rd_ack}, 32'd1);
    chk(tag, {28'b0, bus4.rd_data}, exp);
  endtask

  // clear, enable, then n clean counted cycles, then ecall into HALT
  task automatic run_clean(input int n);
    bus.cfg_clear = 1; tick(1); bus.cfg_clear = 0;
    bus.cfg_enable = 1; tick(1); bus.cfg_enable = 0;
    tick(n);
    bus.stat_ecall = 1; tick(1); bus.stat_ecall = 0;
  endtask

  task automatic run4_clean(input int n);
    bus4.cfg_clear = 1; tick(1); bus4.cfg_clear = 0;
    bus4.cfg_enable = 1; tick(1); bus4.cfg_enable = 0;
    tick(n);
    bus4.stat_ecall = 1; tick(1); bus4.stat_ecall = 0;
  endtask

  initial begin
    int acks;
    logic [31:0] v [2];

    rst_n = 0;
    zero_inputs();
    tick(2);
    chk("rst_ack",   {31'b0, bus.rd_ack}, 32'd0);
    chk("rst_data",  bus.rd_data, 32'd0);
    chk("rst_state", {30'b0, bus.state_o}, 32'd0);
    rst_n = 1;
    tick(1);
    rd_chk("rst_cyc", 5'd0, 32'd0);

    // 1: ten clean cycles then ecall; later events must not count
    bus.cfg_enable = 1; tick(1); bus.cfg_enable = 0;
    chk("t1_run", {30'b0, bus.state_o}, 32'd1);
    tick(10);
    bus.stat_ecall = 1; tick(1); bus.stat_ecall = 0;
    chk("t1_halt", {30'b0, bus.state_o}, 32'd2);
    bus.stat_PL_stall_if = 1; bus.stat_PL_flush = 1; bus.stat_bne = 1; bus.cfg_enable = 1;
    tick(3);
    bus.stat_PL_stall_if = 0; bus.stat_PL_flush = 0; bus.stat_bne = 0; bus.cfg_enable = 0;
    chk("t1_sticky", {30'b0, bus.state_o}, 32'd2);
    rd_chk("t1_cyc",   5'd0, 32'd10);
    rd_chk("t1_instr", 5'd1, 32'd10);
    rd_chk("t1_stif",  5'd2, 32'd0);
    rd_chk("t1_pt0",   5'd4, 32'd0);

    // 2: stalls then flushes
    bus.cfg_clear = 1; tick(1); bus.cfg_clear = 0;
    chk("t2_idle", {30'b0, bus.state_o}, 32'd0);
    bus.cfg_enable = 1; tick(1); bus.cfg_enable = 0;
    bus.stat_PL_stall_if = 1; bus.stat_PL_stall_ex = 1; tick(3);
    bus.stat_PL_stall_if = 0; bus.stat_PL_stall_ex = 0;
    bus.stat_PL_flush = 1; tick(2); bus.stat_PL_flush = 0;
    bus.stat_ecall = 1; tick(1); bus.stat_ecall = 0;
    rd_chk("t2_cyc",   5'd0, 32'd5);
    rd_chk("t2_instr", 5'd1, 32'hFFFF_FFFC);
    rd_chk("t2_stif",  5'd2, 32'd3);
    rd_chk("t2_stex",  5'd3, 32'd3);

    // 3: branch type and flush attribution
    bus.cfg_clear = 1; tick(1); bus.cfg_clear = 0;
    bus.cfg_enable = 1; tick(1); bus.cfg_enable = 0;
    bus.stat_bne = 1; bus.stat_PL_flush = 1; tick(1);
    bus.stat_PL_flush = 0; tick(1);
    bus.stat_bne = 0; bus.stat_jal = 1; tick(1); bus.stat_jal = 0;
    bus.stat_ecall = 1; tick(1); bus.stat_ecall = 0;
    rd_chk("t3_pt0",   5'd4,  32'd3);
    rd_chk("t3_pf0",   5'd13, 32'd1);
    rd_chk("t3_pt2",   5'd6,  32'd2);
    rd_chk("t3_pf2",   5'd15, 32'd1);
    rd_chk("t3_pt7",   5'd11, 32'd1);
    rd_chk("t3_pf7",   5'd20, 32'd0);
    rd_chk("t3_pt1",   5'd5,  32'd0);
    rd_chk("t3_instr", 5'd1,  32'd0);

    // 4: held request while counting, then an unmapped address
    bus.cfg_clear = 1; tick(1); bus.cfg_clear = 0;
    bus.cfg_enable = 1; tick(1); bus.cfg_enable = 0;
    acks = 0; v[0] = '1; v[1] = '1;
    bus.rd_req = 1; bus.rd_addr = 5'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.rd_ack) begin
        if (acks < 2) v[acks] = bus.rd_data;
        acks++;
      end
    end
    bus.rd_req = 0;
    chk("t4_acks", acks, 32'd2);
    chk("t4_v0", v[0], 32'd0);
    chk("t4_v1", v[1], 32'd2);
    rd_chk("t4_addr25", 5'd25, 32'd0);

    // 5: clear racing a read of CYC=7
    run_clean(7);
    bus.cfg_clear = 1; bus.rd_req = 1; bus.rd_addr = 5'd0;
    tick(1);
    bus.cfg_clear = 0; bus.rd_req = 0;
    chk("t5_ack",   {31'b0, bus.rd_ack}, 32'd1);
    chk("t5_data",  bus.rd_data, 32'd7);
    chk("t5_state", {30'b0, bus.state_o}, 32'd0);
    tick(1);
    rd_chk("t5_cyc",   5'd0, 32'd0);
    rd_chk("t5_stif",  5'd2, 32'd0);

    // 6: 4-bit counters wrap 15 -> 0 -> 1
    run4_clean(15);
    rd4_chk("t6_15", 5'd0, 32'd15);
    run4_clean(16);
    rd4_chk("t6_0", 5'd0, 32'd0);
    run4_clean(17);
    rd4_chk("t6_1", 5'd0, 32'd1);
    rd4_chk("t6_instr", 5'd1, 32'd1);

    // 7: reset while an ack is in flight
    bus.rd_req = 1; bus.rd_addr = 5'd0;
    tick(1);
    chk("t7_pre_ack", {31'b0, bus.rd_ack}, 32'd1);
    rst_n = 0;
    #1;
    chk("t7_ack_drop", {31'b0, bus.rd_ack}, 32'd0);
    chk("t7_data_rst", bus.rd_data, 32'd0);
    bus.rd_req = 0;
    tick(2);
    rst_n = 1;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.rd_ack) acks++;
    end
    chk("t7_no_ack", acks, 32'd0);
    chk("t7_state", {30'b0, bus.state_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
